// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle controller: FSM state
//               codes, legal opcode values, ALUOp encodings and the decoded
//               opcode-class enum.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM state encodings (also driven on the debug state port)
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;

    // Legal instruction[6:0] opcodes
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;

    // ALUOp encodings
    localparam logic [1:0] c_ALUOP_ADD    = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT  = 2'b10;

    // Wait counter width; covers the largest supported MEM_TIMEOUT (255)
    localparam int c_WAIT_W = 8;

    // Decoded opcode class; CLS_NONE is the cleared/illegal value
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_IALU   = 3'd5
    } opclass_t;

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_opcode_decoder
// Description : Combinational map from the 7-bit opcode to an opcode class
//               and a legal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opclass_t   o_class,
    output logic       o_legal
);

    // Classify the opcode; anything not listed is illegal
    always_comb begin
        o_class = CLS_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            c_OP_R:      o_class = CLS_R;
            c_OP_LOAD:   o_class = CLS_LOAD;
            c_OP_STORE:  o_class = CLS_STORE;
            c_OP_BRANCH: o_class = CLS_BRANCH;
            c_OP_IALU:   o_class = CLS_IALU;
            default:     o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Five-state (FETCH/DECODE/EXEC/MEM/WB) control FSM for a
//               multicycle datapath, with a memory-wait timeout.
//               Optional macro MC_CTRL_PERF_EN adds 32-bit cycle_count and
//               instr_count performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        timeout_err,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    // Wait count value at which the current waiting cycle is the last one allowed
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    opclass_t            r_class;
    opclass_t            w_dec_class;
    logic                w_dec_legal;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_in_wait_state;
    logic                w_timeout;
    logic                w_waiting;

    logic                w_pc_write;
    logic                w_ir_write;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_reg_write;
    logic                w_mem_to_reg;
    logic                w_alu_src;
    logic [1:0]          w_alu_op;
    logic                w_instr_done;
    logic                w_illegal_op;
    logic                w_timeout_err;

    mc_opcode_decoder u_decoder (
        .i_opcode (opcode),
        .o_class  (w_dec_class),
        .o_legal  (w_dec_legal)
    );

    // mem_ready only matters in FETCH and MEM; a same-cycle ready beats the timeout
    assign w_in_wait_state = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM);
    assign w_timeout       = w_in_wait_state && !mem_ready && (r_wait >= c_WAIT_LIMIT);
    assign w_waiting       = w_in_wait_state && !mem_ready && !w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode class captured in DECODE for use by EXEC/MEM/WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class <= CLS_NONE;
        end else if (r_state == c_ST_DECODE) begin
            r_class <= w_dec_class;
        end
    end

    // Wait counter: counts stalled cycles, restarts whenever the state is (re)entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_waiting) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH: begin
                if (mem_ready)      w_next_state = c_ST_DECODE;
                else                w_next_state = c_ST_FETCH;
            end
            c_ST_DECODE: begin
                if (w_dec_legal)    w_next_state = c_ST_EXEC;
                else                w_next_state = c_ST_FETCH;
            end
            c_ST_EXEC: begin
                case (r_class)
                    CLS_R, CLS_IALU:     w_next_state = c_ST_WB;
                    CLS_LOAD, CLS_STORE: w_next_state = c_ST_MEM;
                    default:             w_next_state = c_ST_FETCH;
                endcase
            end
            c_ST_MEM: begin
                if (mem_ready)      w_next_state = (r_class == CLS_LOAD) ? c_ST_WB : c_ST_FETCH;
                else if (w_timeout) w_next_state = c_ST_FETCH;
                else                w_next_state = c_ST_MEM;
            end
            c_ST_WB:                w_next_state = c_ST_FETCH;
            default:                w_next_state = c_ST_FETCH;
        endcase
    end

    // Output decode from state, registered class, zero and mem_ready
    always_comb begin
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src     = 1'b0;
        w_alu_op      = c_ALUOP_ADD;
        w_instr_done  = 1'b0;
        w_illegal_op  = 1'b0;
        w_timeout_err = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (w_timeout) begin
                    w_timeout_err = 1'b1;
                end else begin
                    w_mem_read = 1'b1;
                    if (mem_ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                    end
                end
            end
            c_ST_DECODE: begin
                w_illegal_op = !w_dec_legal;
            end
            c_ST_EXEC: begin
                w_alu_src = (r_class == CLS_LOAD) || (r_class == CLS_STORE) ||
                            (r_class == CLS_IALU);
                case (r_class)
                    CLS_R:      w_alu_op = c_ALUOP_FUNCT;
                    CLS_BRANCH: w_alu_op = c_ALUOP_BRANCH;
                    default:    w_alu_op = c_ALUOP_ADD;
                endcase
                if (r_class == CLS_BRANCH) begin
                    w_pc_write   = zero;
                    w_instr_done = 1'b1;
                end
            end
            c_ST_MEM: begin
                if (w_timeout) begin
                    w_timeout_err = 1'b1;
                end else begin
                    w_mem_read   = (r_class == CLS_LOAD);
                    w_mem_write  = (r_class == CLS_STORE);
                    w_instr_done = mem_ready && (r_class == CLS_STORE);
                end
            end
            c_ST_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_class == CLS_LOAD);
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Every output is held low while reset is asserted
    assign pc_write    = w_pc_write    & ~reset;
    assign ir_write    = w_ir_write    & ~reset;
    assign mem_read    = w_mem_read    & ~reset;
    assign mem_write   = w_mem_write   & ~reset;
    assign reg_write   = w_reg_write   & ~reset;
    assign mem_to_reg  = w_mem_to_reg  & ~reset;
    assign alu_src     = w_alu_src     & ~reset;
    assign alu_op      = w_alu_op      & {2{~reset}};
    assign instr_done  = w_instr_done  & ~reset;
    assign illegal_op  = w_illegal_op  & ~reset;
    assign timeout_err = w_timeout_err & ~reset;
    assign state       = r_state       & {3{~reset}};

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;

    // Free-running cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_instr_done) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller,
//               built with MEM_TIMEOUT=4. Honours MC_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    localparam int c_TIMEOUT = 4;

    // Expected-enable patterns: {pc_write, ir_write, mem_read, mem_write,
    //                            reg_write, mem_to_reg, alu_src}
    localparam logic [6:0] c_EN_NONE  = 7'b0000000;
    localparam logic [6:0] c_EN_FETCH = 7'b1110000;
    localparam logic [6:0] c_EN_RD    = 7'b0010000;
    localparam logic [6:0] c_EN_WR    = 7'b0001000;
    localparam logic [6:0] c_EN_REG   = 7'b0000100;
    localparam logic [6:0] c_EN_REGLD = 7'b0000110;
    localparam logic [6:0] c_EN_SRC   = 7'b0000001;
    localparam logic [6:0] c_EN_PC    = 7'b1000000;

    // Expected-status patterns: {instr_done, illegal_op, timeout_err}
    localparam logic [2:0] c_S_NONE = 3'b000;
    localparam logic [2:0] c_S_DONE = 3'b100;
    localparam logic [2:0] c_S_ILL  = 3'b010;
    localparam logic [2:0] c_S_TO   = 3'b001;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [6:0] opcode    = 7'd0;
    logic       zero      = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src;
    logic [1:0] alu_op;
    logic       instr_done, illegal_op, timeout_err;
    logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int errors = 0;
    int checks = 0;

    multicycle_controller #(.MEM_TIMEOUT(c_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .timeout_err (timeout_err),
        .state       (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    // Observed output bundle, ordered as {enables, alu_op, status, state}
    logic [14:0] w_obs;
    assign w_obs = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
                    alu_src, alu_op, instr_done, illegal_op, timeout_err, state};

    task automatic chk(input string tag, input logic [2:0] st, input logic [6:0] en,
                       input logic [1:0] aop, input logic [2:0] stat);
        logic [14:0] exp_v;
        exp_v = {en, aop, stat, st};
        checks++;
        assert (w_obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, w_obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; drive the new cycle's inputs just after the edge
    task automatic tick(input logic rdy, input logic z);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    initial begin
        // Reset held: every output low regardless of inputs
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        opcode    = c_OP_R;
        #1;
        chk("reset_hold", c_ST_FETCH, c_EN_NONE, 2'b00, c_S_NONE);

        // R-type, memory ready immediately: F, D, E, W
        reset = 1'b0;
        #1;
        chk("r_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b1, 1'b0);
        chk("r_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b1, 1'b0);
        chk("r_exec", c_ST_EXEC, c_EN_NONE, 2'b10, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("r_wb", c_ST_WB, c_EN_REG, 2'b00, c_S_DONE);

        // LOAD with three stalled MEM cycles: 8 cycles total
        opcode = c_OP_LOAD;
        tick(1'b1, 1'b0);
        chk("ld_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
`ifdef MC_CTRL_PERF_EN
        chk32("perf_cycles_r", cycle_count, 32'd4);
        chk32("perf_instr_r", instr_count, 32'd1);
`endif
        tick(1'b0, 1'b0);
        chk("ld_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ld_exec", c_ST_EXEC, c_EN_SRC, 2'b00, c_S_NONE);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("ld_mem_wait", c_ST_MEM, c_EN_RD, 2'b00, c_S_NONE);
        end
        tick(1'b1, 1'b0);
        chk("ld_mem_ready", c_ST_MEM, c_EN_RD, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ld_wb", c_ST_WB, c_EN_REGLD, 2'b00, c_S_DONE);

        // BRANCH taken (zero=1)
        opcode = c_OP_BRANCH;
        tick(1'b1, 1'b0);
        chk("bt_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("bt_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b1);
        chk("bt_exec", c_ST_EXEC, c_EN_PC, 2'b01, c_S_DONE);

        // BRANCH not taken (zero=0)
        tick(1'b1, 1'b0);
        chk("bn_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("bn_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("bn_exec", c_ST_EXEC, c_EN_NONE, 2'b01, c_S_DONE);

        // Illegal opcode: pulse in DECODE, back to FETCH
        opcode = 7'b1111111;
        tick(1'b1, 1'b0);
        chk("ill_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ill_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_ILL);

        // FETCH stalls until the timeout fires on its 4th cycle
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("fetch_wait", c_ST_FETCH, c_EN_RD, 2'b00, c_S_NONE);
        end
        tick(1'b0, 1'b0);
        chk("fetch_timeout", c_ST_FETCH, c_EN_NONE, 2'b00, c_S_TO);
        tick(1'b0, 1'b0);
        chk("fetch_after_to", c_ST_FETCH, c_EN_RD, 2'b00, c_S_NONE);

        // STORE with no memory response: timeout on the 4th MEM cycle
        opcode = c_OP_STORE;
        tick(1'b1, 1'b0);
        chk("sto_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("sto_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("sto_exec", c_ST_EXEC, c_EN_SRC, 2'b00, c_S_NONE);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("sto_mem_wait", c_ST_MEM, c_EN_WR, 2'b00, c_S_NONE);
        end
        tick(1'b0, 1'b0);
        chk("sto_timeout", c_ST_MEM, c_EN_NONE, 2'b00, c_S_TO);
        tick(1'b0, 1'b0);
        chk("sto_to_fetch", c_ST_FETCH, c_EN_RD, 2'b00, c_S_NONE);

        // STORE with mem_ready on the would-be timeout cycle: ready wins
        tick(1'b1, 1'b0);
        chk("st_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("st_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("st_exec", c_ST_EXEC, c_EN_SRC, 2'b00, c_S_NONE);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("st_mem_wait", c_ST_MEM, c_EN_WR, 2'b00, c_S_NONE);
        end
        tick(1'b1, 1'b0);
        chk("st_ready_at_limit", c_ST_MEM, c_EN_WR, 2'b00, c_S_DONE);

        // IALU: alu_src=1, WB without mem_to_reg, never a MEM read
        opcode = c_OP_IALU;
        tick(1'b1, 1'b0);
        chk("ia_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ia_decode", c_ST_DECODE, c_EN_NONE, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ia_exec", c_ST_EXEC, c_EN_SRC, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        chk("ia_wb", c_ST_WB, c_EN_REG, 2'b00, c_S_DONE);

        // Reset asserted in MEM of a STORE
        opcode = c_OP_STORE;
        tick(1'b1, 1'b0);
        chk("rs_fetch", c_ST_FETCH, c_EN_FETCH, 2'b00, c_S_NONE);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rs_mem", c_ST_MEM, c_EN_WR, 2'b00, c_S_NONE);
        reset = 1'b1;
        #1;
        chk("rs_async_drop", c_ST_FETCH, c_EN_NONE, 2'b00, c_S_NONE);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rs_release", c_ST_FETCH, c_EN_RD, 2'b00, c_S_NONE);
`ifdef MC_CTRL_PERF_EN
        chk32("perf_cycles_rst", cycle_count, 32'd0);
        chk32("perf_instr_rst", instr_count, 32'd0);
        tick(1'b0, 1'b0);
        chk32("perf_cycles_one", cycle_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: cycles waiting on mem_ready before abort; range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; sampled in EXEC.
REQ-006 mem_ready  input  1  shared memory completion strobe for the current fetch, load or store.
REQ-007 pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src  output  1 each  datapath enables.
REQ-008 alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-009 instr_done, illegal_op, timeout_err  output  1 each  single-cycle status pulses.
REQ-010 state  output  3  current FSM state, for debug.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, EXEC, MEM and WB, encoded in package constants.
REQ-012 FETCH SHALL assert mem_read; on mem_ready it SHALL pulse ir_write and pc_write (PC+4) in the same cycle and go to DECODE.
REQ-013 DECODE SHALL register the opcode class; legal classes are R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, IALU 0010011.
REQ-014 An illegal opcode in DECODE SHALL pulse illegal_op for one cycle and return to FETCH with no write enables asserted.
REQ-015 EXEC SHALL drive alu_src=1 for LOAD/STORE/IALU, else 0; alu_op=10 for R, 01 for BRANCH, 00 otherwise.
REQ-016 EXEC routing: R/IALU to WB; LOAD/STORE to MEM; BRANCH to FETCH with pc_write=zero and instr_done=1.
REQ-017 MEM SHALL assert mem_read (LOAD) or mem_write (STORE) until mem_ready; on mem_ready LOAD goes to WB, STORE to FETCH with instr_done=1.
REQ-018 WB SHALL assert reg_write=1 for one cycle, mem_to_reg=1 only for LOAD, pulse instr_done, and go to FETCH.
REQ-019 IALU SHALL NOT assert mem_read in any state.
REQ-020 mem_read and mem_write SHALL never be asserted together.
REQ-021 Latency: R/IALU 4 cycles, BRANCH 3, STORE 4, LOAD 5, each plus memory wait cycles.
REQ-022 The wait counter SHALL reset on every state entry and count cycles in FETCH/MEM with mem_ready=0.
REQ-023 When the wait count reaches MEM_TIMEOUT, the FSM SHALL pulse timeout_err, drop all enables, and go to FETCH without pc_write.
REQ-024 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-025 mem_ready in the same cycle as the timeout SHALL take priority; no timeout_err is raised.
REQ-026 Outputs SHALL be combinational from state, the registered class, zero and mem_ready; none are registered.

Reset
REQ-027 Reset SHALL force state=FETCH, clear the class register and wait counter, and force every output to 0 while asserted.
REQ-028 Reset mid-instruction SHALL abandon the instruction without a completion pulse; mem_read rises in the first cycle after deassertion.

Configuration
REQ-029 With MC_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs cycle_count (every non-reset cycle) and instr_count (per instr_done), both wrapping, both cleared by reset.
REQ-030 Without MC_CTRL_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold state encodings, opcode constants, ALUOp encodings and the opcode-class enum.
REQ-032 Sub-module mc_opcode_decoder SHALL map opcode to class plus legal flag, combinationally.

Verification
REQ-033 R-type 0110011 with mem_ready=1 in FETCH: states F,D,E,W; reg_write=1 in WB only; alu_op=10 in EXEC; instr_done in cycle 4.
REQ-034 LOAD 0000011 with mem_ready delayed 3 cycles in MEM: mem_read held 4 MEM cycles; WB with mem_to_reg=1; total 8 cycles.
REQ-035 BRANCH 1100011 with zero=1: pc_write=1 in EXEC; repeat with zero=0: pc_write=0; both 3 cycles.
REQ-036 Opcode 1111111: illegal_op pulse in DECODE, next state FETCH, no reg_write or mem_write.
REQ-037 MEM_TIMEOUT=4, STORE with mem_ready=0: timeout_err after 4 MEM cycles, then FETCH; mem_ready on that cycle instead gives instr_done and no error.
REQ-038 Reset asserted in MEM of a STORE: mem_write drops asynchronously; after release, state=FETCH and mem_read=1; with MC_CTRL_PERF_EN, both counters read 0.
